// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// Reads the word at the PC over a req/ack memory handshake, strobes it into the
// instruction register for one cycle, then advances the PC. A fetch whose
// memory never acknowledges is abandoned after TIMEOUT request cycles.
module fetch_unit #(
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_in,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] ir_data,
  output logic          ir_w,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          fetch_done,
  output logic          fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    LOAD = 2'b10
  } state_t;

  localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [AW-1:0] PC_ONE   = AW'(1);

  state_t        state_r, next_state_s;
  logic [7:0]    cnt_r, cnt_s;
  logic [AW-1:0] pc_s, addr_s;
  logic [DW-1:0] ir_data_s;
  logic          rd_s, ir_w_s, done_s, err_s, busy_s;

  // State register; reset returns the sequencer to IDLE at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    next_state_s = state_r;
    cnt_s        = cnt_r;
    pc_s         = pc;
    addr_s       = mem_addr;
    rd_s         = mem_rd;
    ir_data_s    = ir_data;
    ir_w_s       = 1'b0;
    done_s       = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        // A branch target loaded in the same cycle as a fetch is the address fetched.
        if (pc_load) begin
          pc_s = pc_in;
        end else begin
          pc_s = pc;
        end
        if (fetch_req) begin
          next_state_s = REQ;
          rd_s         = 1'b1;
          cnt_s        = 8'd0;
          addr_s       = pc_load ? pc_in : pc;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          next_state_s = LOAD;
          ir_data_s    = mem_rdata;
          rd_s         = 1'b0;
          cnt_s        = 8'd0;
          ir_w_s       = 1'b1;
          done_s       = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          // Memory never answered: drop the request, keep PC and IR contents.
          next_state_s = IDLE;
          rd_s         = 1'b0;
          cnt_s        = 8'd0;
          err_s        = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      LOAD: begin
        // AW-bit add wraps naturally from the top address to zero.
        pc_s         = pc + PC_ONE;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
        rd_s         = 1'b0;
        cnt_s        = 8'd0;
      end
    endcase
    busy_s = (next_state_s != IDLE);
  end

  // Output and datapath registers; async reset also drops mem_rd immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= 8'd0;
      pc         <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      ir_data    <= '0;
      ir_w       <= 1'b0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      pc         <= pc_s;
      mem_addr   <= addr_s;
      mem_rd     <= rd_s;
      ir_data    <= ir_data_s;
      ir_w       <= ir_w_s;
      fetch_done <= done_s;
      fetch_err  <= err_s;
      busy       <= busy_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed fetches with a scoreboard queue checked
// by an independent monitor on every ir_w / fetch_err event.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        pc_load;
  logic [9:0]  pc_in;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [15:0] ir_data;
  logic        ir_w;
  logic [9:0]  pc;
  logic        busy;
  logic        fetch_done;
  logic        fetch_err;

  typedef struct {
    logic        is_err;
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   irw_seen = 0;
  logic noise    = 1'b0;

  fetch_unit #(.AW(10), .DW(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_in(pc_in), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .ir_data(ir_data), .ir_w(ir_w),
    .pc(pc), .busy(busy), .fetch_done(fetch_done), .fetch_err(fetch_err)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per delivered word or timeout pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (ir_w || fetch_err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, ir_w, fetch_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (ir_w) irw_seen++;
          check("event_kind", {31'd0, fetch_err}, {31'd0, e.is_err});
          check("done_eq_irw", {31'd0, fetch_done}, {31'd0, ir_w});
          if (!e.is_err) begin
            check("ir_data", {16'd0, ir_data}, {16'd0, e.data});
            check("load_addr", {22'd0, mem_addr}, {22'd0, e.addr});
          end else begin
            check("err_no_irw", {31'd0, ir_w}, 32'd0);
          end
        end
      end
    end
  end

  // One fetch: request at a negedge, ack after wait_n wait cycles.
  task automatic do_fetch(input logic ld, input logic [9:0] tgt, input int wait_n,
                          input logic [15:0] data, input logic [9:0] exp_addr,
                          input logic [9:0] exp_pc);
    exp_t e;
    @(negedge clk);
    fetch_req = 1'b1; pc_load = ld; pc_in = tgt;
    @(negedge clk);
    fetch_req = 1'b0; pc_load = 1'b0;
    check("req_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < wait_n; i++) begin
      check("wait_rd", {31'd0, mem_rd}, 32'd1);
      check("wait_addr", {22'd0, mem_addr}, {22'd0, exp_addr});
      mem_ack = 1'b0;
      if (noise) begin
        fetch_req = 1'b1; pc_load = 1'b1; pc_in = 10'd5;
      end else begin
        fetch_req = 1'b0;
      end
      @(negedge clk);
    end
    fetch_req = 1'b0; pc_load = 1'b0;
    check("ack_rd", {31'd0, mem_rd}, 32'd1);
    check("ack_addr", {22'd0, mem_addr}, {22'd0, exp_addr});
    mem_ack = 1'b1; mem_rdata = data;
    e.is_err = 1'b0; e.addr = exp_addr; e.data = data;
    exp_q.push_back(e);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    check("load_rd_low", {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    check("pc_after", {22'd0, pc}, {22'd0, exp_pc});
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [15:0] ir_before;
    logic [9:0]  pc_before;
    rst = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_in = 10'd0;
    mem_rdata = 16'd0; mem_ack = 1'b0;
    #1;
    check("rst_pc", {22'd0, pc}, 32'd0);
    check("rst_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_ir", {16'd0, ir_data}, 32'd0);
    check("rst_flags", {28'd0, ir_w, busy, fetch_done, fetch_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic zero-wait fetch from address 0
    do_fetch(1'b0, 10'd0, 0, 16'b0110101010110011, 10'd0, 10'd1);
    // Three wait cycles: mem_rd held four cycles at address 1
    do_fetch(1'b0, 10'd0, 3, 16'b0001011011110100, 10'd1, 10'd2);
    // Branch loaded in the same cycle as the fetch
    do_fetch(1'b1, 10'b1010110011, 0, 16'hBEEF, 10'b1010110011, 10'b1010110100);
    // Wrap from 1023 with requests and loads injected while busy
    noise = 1'b1;
    do_fetch(1'b1, 10'd1023, 2, 16'h1234, 10'd1023, 10'd0);
    noise = 1'b0;
    @(negedge clk);
    check("dropped_req_busy", {31'd0, busy}, 32'd0);
    check("dropped_load_pc", {22'd0, pc}, 32'd0);
    // Plain fetch so PC is nonzero before the timeout and reset tests
    do_fetch(1'b0, 10'd0, 0, 16'h00FF, 10'd0, 10'd1);

    // Timeout: memory never acknowledges
    ir_before = ir_data; pc_before = pc;
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("to_rd_high", {31'd0, mem_rd}, 32'd1);
      if (i == 14) begin
        e.is_err = 1'b1; e.addr = 10'd1; e.data = 16'd0;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    check("to_rd_low", {31'd0, mem_rd}, 32'd0);
    check("to_fetch_err", {31'd0, fetch_err}, 32'd1);
    check("to_pc", {22'd0, pc}, {22'd0, pc_before});
    check("to_ir", {16'd0, ir_data}, {16'd0, ir_before});
    @(negedge clk);
    check("to_err_pulse", {31'd0, fetch_err}, 32'd0);

    // Reset while a request is outstanding
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    check("pre_rst_rd", {31'd0, mem_rd}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rd", {31'd0, mem_rd}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_pc", {22'd0, pc}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_no_done", {30'd0, ir_w, fetch_done}, 32'd0);
    check("irw_total", irw_seen, 32'd5);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
